// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, instruction field layout, op codes and
// the instruction decoder used by the decode/issue stage.
package pipe_pkg;
  localparam int DATA_W       = 16;
  localparam int NUM_REGS_DEF = 8;
  localparam int INSTR_W      = 16;
  localparam int ADDR_W       = 4;

  localparam int WRD_BIT  = 15;
  localparam int USE1_BIT = 14;
  localparam int USE2_BIT = 13;
  localparam int OP_HI    = 12;
  localparam int OP_LO    = 11;
  localparam int RD_HI    = 10;
  localparam int RD_LO    = 8;
  localparam int RS1_HI   = 7;
  localparam int RS1_LO   = 5;
  localparam int RS2_HI   = 4;
  localparam int RS2_LO   = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  typedef struct packed {
    logic       writes_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    op_e        op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
  } dec_t;

  function automatic dec_t decode(input logic [INSTR_W-1:0] instr);
    dec_t d;
    d.writes_rd = instr[WRD_BIT];
    d.uses_rs1  = instr[USE1_BIT];
    d.uses_rs2  = instr[USE2_BIT];
    d.op        = op_e'(instr[OP_HI:OP_LO]);
    d.rd        = instr[RD_HI:RD_LO];
    d.rs1       = instr[RS1_HI:RS1_LO];
    d.rs2       = instr[RS2_HI:RS2_LO];
    return d;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set by issue, cleared by writeback or by killing the
// instruction held in EX. A set always wins over a clear of the same register.
module reg_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic                kill_en,
  input  logic [ADDR_W-1:0]   kill_addr,
  output logic [NUM_REGS-1:0] busy
);
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Addresses at or above NUM_REGS simply never match any index.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_d[i] = (set_en && set_addr == ADDR_W'(i)) ||
                  (busy_q[i] && !(clr_en && clr_addr == ADDR_W'(i))
                             && !(kill_en && kill_addr == ADDR_W'(i)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes the fetched instruction, reads and bypasses
// operands, checks the scoreboard and issues into a single EX register.
module decode_issue
  import pipe_pkg::*;
#(
  parameter int N        = DATA_W,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [15:0]         if_instr,
  output logic                if_ready,
  output logic [3:0]          rf_read_addr1,
  output logic [3:0]          rf_read_addr2,
  input  logic [N-1:0]        rf_read_data1,
  input  logic [N-1:0]        rf_read_data2,
  input  logic                wb_en,
  input  logic [3:0]          wb_addr,
  input  logic [N-1:0]        wb_data,
  input  logic                flush,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [1:0]          ex_op,
  output logic [3:0]          ex_rd,
  output logic                ex_wen,
  output logic [N-1:0]        ex_a,
  output logic [N-1:0]        ex_b,
  output logic [NUM_REGS-1:0] busy,
  output logic [15:0]         stall_count
);
  dec_t          dec;
  logic [7:0]    busy8;
  logic [7:0]    wb_hit8;
  logic [7:0]    busy_eff;
  logic          hazard;
  logic          can_accept;
  logic          issue;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic          unused_bits;

  logic          ex_valid_q, ex_valid_d;
  op_e           ex_op_q, ex_op_d;
  logic [3:0]    ex_rd_q, ex_rd_d;
  logic          ex_wen_q, ex_wen_d;
  logic [N-1:0]  ex_a_q, ex_a_d;
  logic [N-1:0]  ex_b_q, ex_b_d;
  logic [15:0]   stall_count_q, stall_count_d;

  assign dec           = decode(if_instr);
  assign unused_bits   = ^if_instr[1:0];
  assign rf_read_addr1 = {1'b0, dec.rs1};
  assign rf_read_addr2 = {1'b0, dec.rs2};

  // 3-bit register fields can only reach the low eight busy bits.
  generate
    if (NUM_REGS >= 8) begin : g_busy_wide
      assign busy8 = busy[7:0];
    end else begin : g_busy_narrow
      assign busy8 = {{(8-NUM_REGS){1'b0}}, busy};
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_wb_hit
      assign wb_hit8[gi] = wb_en && (wb_addr == 4'(gi));
    end
  endgenerate

  assign busy_eff = busy8 & ~wb_hit8;

  always_comb begin
    hazard = if_valid && ((dec.uses_rs1  && busy_eff[dec.rs1]) ||
                          (dec.uses_rs2  && busy_eff[dec.rs2]) ||
                          (dec.writes_rd && busy_eff[dec.rd]));
    can_accept = !ex_valid_q || ex_ready;
    if_ready   = rst && can_accept && !hazard && !flush;
    issue      = if_valid && if_ready;
    op_a = (wb_en && wb_addr == rf_read_addr1) ? wb_data : rf_read_data1;
    op_b = (wb_en && wb_addr == rf_read_addr2) ? wb_data : rf_read_data2;
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_op_d       = ex_op_q;
    ex_rd_d       = ex_rd_q;
    ex_wen_d      = ex_wen_q;
    ex_a_d        = ex_a_q;
    ex_b_d        = ex_b_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (issue) begin
      ex_valid_d = 1'b1;
      ex_op_d    = dec.op;
      ex_rd_d    = {1'b0, dec.rd};
      ex_wen_d   = dec.writes_rd;
      ex_a_d     = op_a;
      ex_b_d     = op_b;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
    if (if_valid && !if_ready && stall_count_q != 16'hFFFF) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q    <= 1'b0;
      ex_op_q       <= OP_ADD;
      ex_rd_q       <= '0;
      ex_wen_q      <= 1'b0;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      stall_count_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_op_q       <= ex_op_d;
      ex_rd_q       <= ex_rd_d;
      ex_wen_q      <= ex_wen_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue && dec.writes_rd),
    .set_addr  ({1'b0, dec.rd}),
    .clr_en    (wb_en),
    .clr_addr  (wb_addr),
    .kill_en   (flush && ex_valid_q && ex_wen_q),
    .kill_addr (ex_rd_q),
    .busy      (busy)
  );

  assign ex_valid    = ex_valid_q;
  assign ex_op       = ex_op_q;
  assign ex_rd       = ex_rd_q;
  assign ex_wen      = ex_wen_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a cycle-by-cycle vector table followed by
// hand-written reset-mid-stall and stall-counter saturation sequences.
module tb_decode_issue;
  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        if_ready;
  logic [3:0]  rf_read_addr1, rf_read_addr2;
  logic [15:0] rf_read_data1, rf_read_data2;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [1:0]  ex_op;
  logic [3:0]  ex_rd;
  logic        ex_wen;
  logic [15:0] ex_a, ex_b;
  logic [7:0]  busy;
  logic [15:0] stall_count;

  int checks;
  int failures;

  decode_issue dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .rf_read_addr1(rf_read_addr1),
    .rf_read_addr2(rf_read_addr2), .rf_read_data1(rf_read_data1),
    .rf_read_data2(rf_read_data2), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_op(ex_op), .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_a(ex_a), .ex_b(ex_b), .busy(busy), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] instr;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        wbe;
    logic [3:0]  wba;
    logic [15:0] wbd;
    logic        fl;
    logic        exr;
    logic        ifr;
    logic        exv;
    logic [15:0] exa;
    logic [15:0] exb;
    logic [3:0]  exrd;
    logic [1:0]  exop;
    logic        exw;
    logic [7:0]  bsy;
    logic [15:0] stl;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] instr, input logic [15:0] d1,
                       input logic [15:0] d2, input logic wbe, input logic [3:0] wba,
                       input logic [15:0] wbd, input logic fl, input logic exr);
    if_valid      = iv;
    if_instr      = instr;
    rf_read_data1 = d1;
    rf_read_data2 = d2;
    wb_en         = wbe;
    wb_addr       = wba;
    wb_data       = wbd;
    flush         = fl;
    ex_ready      = exr;
  endtask

  task automatic do_reset();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] ins;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);

    //        iv instr     d1   d2   wbe wba  wbd  fl exr ifr exv exa  exb  exrd exop exw bsy    stl
    vecs[0]  = '{1, 16'hE128, 100, 150, 0, 4'd0, 0,   0, 1,  1,  1,  100, 150, 1, 0, 1, 8'h02, 0};
    vecs[1]  = '{1, 16'h4820, 7,   9,   0, 4'd0, 0,   0, 1,  0,  0,  100, 150, 1, 0, 1, 8'h02, 1};
    vecs[2]  = '{1, 16'h4820, 7,   9,   0, 4'd0, 0,   0, 1,  0,  0,  100, 150, 1, 0, 1, 8'h02, 2};
    vecs[3]  = '{1, 16'h4820, 7,   9,   1, 4'd1, 500, 0, 1,  1,  1,  500, 9,   0, 1, 0, 8'h00, 2};
    vecs[4]  = '{1, 16'hF770, 30,  40,  0, 4'd0, 0,   0, 0,  0,  1,  500, 9,   0, 1, 0, 8'h00, 3};
    vecs[5]  = '{1, 16'hF770, 30,  40,  0, 4'd0, 0,   0, 0,  0,  1,  500, 9,   0, 1, 0, 8'h00, 4};
    vecs[6]  = '{1, 16'hF770, 30,  40,  0, 4'd0, 0,   0, 0,  0,  1,  500, 9,   0, 1, 0, 8'h00, 5};
    vecs[7]  = '{1, 16'hF770, 30,  40,  0, 4'd0, 0,   0, 1,  1,  1,  30,  40,  7, 2, 1, 8'h80, 5};
    vecs[8]  = '{1, 16'hE128, 100, 150, 0, 4'd0, 0,   1, 0,  0,  0,  30,  40,  7, 2, 1, 8'h00, 6};
    vecs[9]  = '{0, 16'h0000, 0,   0,   0, 4'd0, 0,   0, 1,  1,  0,  30,  40,  7, 2, 1, 8'h00, 6};
    vecs[10] = '{1, 16'hE128, 1,   2,   1, 4'd9, 77,  0, 1,  1,  1,  1,   2,   1, 0, 1, 8'h02, 6};
    vecs[11] = '{0, 16'h0000, 0,   0,   1, 4'd9, 77,  0, 1,  1,  0,  1,   2,   1, 0, 1, 8'h02, 6};
    vecs[12] = '{1, 16'h9900, 11,  12,  1, 4'd1, 5,   0, 1,  1,  1,  11,  12,  1, 3, 1, 8'h02, 6};
    vecs[13] = '{1, 16'h8200, 0,   0,   0, 4'd0, 0,   0, 1,  1,  1,  0,   0,   2, 0, 1, 8'h06, 6};
    vecs[14] = '{0, 16'h0000, 0,   0,   1, 4'd1, 0,   1, 0,  0,  0,  0,   0,   2, 0, 1, 8'h00, 6};

    repeat (2) @(posedge clk);
    #1;
    chk("reset ex_valid", 32'(ex_valid), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset stall_count", 32'(stall_count), 32'h0);
    chk("reset if_ready", 32'(if_ready), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].instr, vecs[i].d1, vecs[i].d2, vecs[i].wbe,
            vecs[i].wba, vecs[i].wbd, vecs[i].fl, vecs[i].exr);
      #1;
      ins = vecs[i].instr;
      chk($sformatf("v%0d rf_read_addr1", i), 32'(rf_read_addr1), 32'({1'b0, ins[7:5]}));
      chk($sformatf("v%0d rf_read_addr2", i), 32'(rf_read_addr2), 32'({1'b0, ins[4:2]}));
      chk($sformatf("v%0d if_ready", i), 32'(if_ready), 32'(vecs[i].ifr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].exv));
      chk($sformatf("v%0d ex_a", i), 32'(ex_a), 32'(vecs[i].exa));
      chk($sformatf("v%0d ex_b", i), 32'(ex_b), 32'(vecs[i].exb));
      chk($sformatf("v%0d ex_rd", i), 32'(ex_rd), 32'(vecs[i].exrd));
      chk($sformatf("v%0d ex_op", i), 32'(ex_op), 32'(vecs[i].exop));
      chk($sformatf("v%0d ex_wen", i), 32'(ex_wen), 32'(vecs[i].exw));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("v%0d stall_count", i), 32'(stall_count), 32'(vecs[i].stl));
      $display("vec %0d instr=%h if_ready=%b ex_valid=%b ex_a=%0d busy=%h stall=%0d",
               i, vecs[i].instr, vecs[i].ifr, ex_valid, ex_a, busy, stall_count);
    end

    // Build busy=06, stall_count=5, then drop reset between clock edges.
    do_reset();
    @(negedge clk);
    drive(1'b1, 16'h8200, 16'd21, 16'd22, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    #1 chk("rst_seq issue rd2 if_ready", 32'(if_ready), 32'h1);
    @(negedge clk);
    drive(1'b1, 16'h9900, 16'd33, 16'd44, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 16'h4820, 16'd1, 16'd2, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_seq busy before", 32'(busy), 32'h06);
    chk("rst_seq stall before", 32'(stall_count), 32'd5);
    chk("rst_seq ex_a before", 32'(ex_a), 32'd33);
    $display("rst_seq built busy=%h stall=%0d", busy, stall_count);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst ex_valid", 32'(ex_valid), 32'h0);
    chk("async rst ex_op", 32'(ex_op), 32'h0);
    chk("async rst ex_rd", 32'(ex_rd), 32'h0);
    chk("async rst ex_wen", 32'(ex_wen), 32'h0);
    chk("async rst ex_a", 32'(ex_a), 32'h0);
    chk("async rst ex_b", 32'(ex_b), 32'h0);
    chk("async rst busy", 32'(busy), 32'h0);
    chk("async rst stall", 32'(stall_count), 32'h0);
    chk("async rst if_ready", 32'(if_ready), 32'h0);
    drive(1'b1, 16'h8200, 16'd5, 16'd6, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("in rst if_ready", 32'(if_ready), 32'h0);
    chk("in rst ex_valid", 32'(ex_valid), 32'h0);
    chk("in rst stall", 32'(stall_count), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post rst if_ready", 32'(if_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("post rst ex_valid", 32'(ex_valid), 32'h1);
    chk("post rst busy", 32'(busy), 32'h04);
    $display("rst_seq released ex_valid=%b busy=%h", ex_valid, busy);

    // Hold a flush-blocked instruction until the stall counter saturates.
    do_reset();
    @(negedge clk);
    drive(1'b1, 16'h0000, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 1'b1);
    repeat (65534) @(posedge clk);
    #1 chk("stall near max", 32'(stall_count), 32'hFFFE);
    repeat (3) @(posedge clk);
    #1 chk("stall saturated", 32'(stall_count), 32'hFFFF);
    $display("sat_seq stall=%h", stall_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter N, default 16, data width of operands and register contents.
REQ-002 SHALL have parameter NUM_REGS, default 8, number of architectural registers tracked.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports if_valid in 1 and if_instr in 16: instruction offered by fetch stage.
REQ-006 SHALL have port if_ready  out  1  instruction accepted this cycle when high with if_valid.
REQ-007 SHALL have ports rf_read_addr1 and rf_read_addr2  out  4  register-file read addresses.
REQ-008 SHALL have ports rf_read_data1 and rf_read_data2  in  N  combinational register-file read data.
REQ-009 SHALL have ports wb_en in 1, wb_addr in 4, wb_data in N: writeback also driving register-file write_enable/write_addr/write_data.
REQ-010 SHALL have port flush  in  1  kill instruction held in the EX register and block issue.
REQ-011 SHALL have ports ex_valid out 1 and ex_ready in 1: valid/ready handshake to execute stage.
REQ-012 SHALL have ports ex_op out 2, ex_rd out 4, ex_wen out 1, ex_a out N, ex_b out N: registered issued instruction.
REQ-013 SHALL have ports busy out NUM_REGS (scoreboard) and stall_count out 16 (saturating stall counter).

Function
REQ-014 SHALL decode if_instr as: [15]=writes_rd, [14]=uses_rs1, [13]=uses_rs2, [12:11]=op, [10:8]=rd, [7:5]=rs1, [4:2]=rs2, [1:0] ignored.
REQ-015 SHALL drive rf_read_addr1={0,rs1} and rf_read_addr2={0,rs2} combinationally from if_instr.
REQ-016 SHALL bypass: operand = wb_data when wb_en and wb_addr equals the source address, else rf_read_data.
REQ-017 SHALL flag hazard when if_valid and any used source, or rd when writes_rd, has busy set and is not being cleared by wb this cycle.
REQ-018 SHALL compute can_accept = !ex_valid || ex_ready; if_ready = can_accept && !hazard && !flush.
REQ-019 SHALL on issue (if_valid && if_ready) load ex_op, ex_rd={0,rd}, ex_wen=writes_rd, ex_a, ex_b and set ex_valid=1 next cycle; latency one cycle.
REQ-020 SHALL clear ex_valid when ex_ready and no issue; hold all ex_* stable while ex_valid && !ex_ready.
REQ-021 SHALL clear busy[wb_addr] on wb_en; wb_addr >= NUM_REGS SHALL be ignored.
REQ-022 SHALL set busy[rd] on issue with writes_rd; same-cycle set and clear of one register SHALL leave it set.
REQ-023 SHALL on flush clear ex_valid next cycle and clear busy[ex_rd] if ex_valid && ex_wen; a wb clear in the same cycle SHALL still apply.
REQ-024 SHALL increment stall_count each cycle if_valid && !if_ready, saturating at 16'hFFFF.
REQ-025 SHALL treat register 0 as an ordinary writable register.

Reset
REQ-026 SHALL on rst low immediately force ex_valid=0, ex_op=0, ex_rd=0, ex_wen=0, ex_a=0, ex_b=0, busy=0, stall_count=0.
REQ-027 SHALL hold if_ready low while rst is low; reset mid-handshake discards the in-flight instruction.

Structure
REQ-028 SHALL take N, NUM_REGS, instruction field positions and op encodings from shared package pipe_pkg.
REQ-029 SHALL implement the busy bits and set/clear priority in sub-module reg_scoreboard.

Verification
REQ-030 SHALL cover: reset, issue 0xE128 (rd1,rs1=1,rs2=2) with rf data 100/150, ex_ready=1 -> ex_valid=1 next cycle, ex_a=100, ex_b=150, busy[1]=1.
REQ-031 SHALL cover: busy[1]=1, offer instr using rs1=1 -> if_ready=0, stall_count increments per cycle; wb_en=1 wb_addr=1 wb_data=500 -> issue same cycle, ex_a=500, busy[1]=0.
REQ-032 SHALL cover: ex_ready=0 with ex_valid=1 -> if_ready=0 and ex_* unchanged for 3 cycles; ex_ready=1 -> next instruction issues.
REQ-033 SHALL cover: flush with ex_valid=1, ex_wen=1, ex_rd=7 -> ex_valid=0 and busy[7]=0 next cycle, no issue that cycle.
REQ-034 SHALL cover: rst asserted mid-stall with busy=8'h06, stall_count=5 -> all outputs zero asynchronously, if_ready=0 until rst high.
